// File: rtl/bhr_pkg.sv
// Shared types and constants for the speculative branch-history controller.
// Optional statistics are enabled by defining BHR_SPEC_STATS_EN.
package bhr_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } bhr_state_t;

    localparam int BHR_DEFAULT_M     = 4;
    localparam int BHR_DEFAULT_DEPTH = 4;
    localparam int BHR_CNT_W         = 16;

endpackage

// File: rtl/bhr_ckpt_fifo.sv
// DEPTH x 1-bit checkpoint queue of in-flight branch predictions.
// A flush empties the queue and overrides any push or pop in the same cycle.
module bhr_ckpt_fifo
    import bhr_pkg::*;
#(
    parameter int DEPTH = BHR_DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic                         head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Guards keep the count inside 0..DEPTH even if a caller misbehaves.
    assign push_ok = push && !flush && (count != FULL_OCC);
    assign pop_ok  = pop  && !flush && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bhr_spec_ctrl.sv
// Speculative/architectural global branch history controller with mispredict repair.
// Define BHR_SPEC_STATS_EN to add saturating resolve/mispredict counters.
module bhr_spec_ctrl
    import bhr_pkg::*;
#(
    parameter int M     = BHR_DEFAULT_M,
    parameter int DEPTH = BHR_DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pred_valid,
    input  logic                         pred_taken,
    output logic                         pred_ready,
    input  logic                         res_valid,
    input  logic                         res_taken,
    output logic                         res_ready,
    output logic [M-1:0]                 spec_hist,
    output logic [M-1:0]                 arch_hist,
    output logic                         mispredict,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef BHR_SPEC_STATS_EN
    ,
    output logic [BHR_CNT_W-1:0]         resolve_count,
    output logic [BHR_CNT_W-1:0]         mispredict_count
`endif
);

    localparam int OCC_W = $clog2(DEPTH+1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    bhr_state_t state;
    logic       pred_fire;
    logic       res_fire;
    logic       ckpt_head;
    logic       mis_event;

    // Handshake readies come only from registered state, never from inputs.
    assign pred_ready = (state == IDLE) && (occupancy < FULL_OCC);
    assign res_ready  = (occupancy != '0);
    assign pred_fire  = pred_valid && pred_ready;
    assign res_fire   = res_valid && res_ready;
    assign mis_event  = res_fire && (res_taken != ckpt_head);

    // A prediction arriving alongside a mispredict is younger and is squashed.
    bhr_ckpt_fifo #(
        .DEPTH (DEPTH)
    ) u_ckpt_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pred_fire && !mis_event),
        .push_data (pred_taken),
        .pop       (res_fire),
        .flush     (mis_event),
        .head      (ckpt_head),
        .count     (occupancy)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            mispredict <= 1'b0;
        end else begin
            mispredict <= mis_event;
            case (state)
                IDLE:    if (mis_event) state <= RECOVER;
                RECOVER: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Repair rebuilds speculative history from the committed history plus the true outcome.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spec_hist <= '0;
            arch_hist <= '0;
        end else begin
            if (mis_event) begin
                spec_hist <= {arch_hist[M-2:0], res_taken};
            end else if (pred_fire) begin
                spec_hist <= {spec_hist[M-2:0], pred_taken};
            end
            if (res_fire) begin
                arch_hist <= {arch_hist[M-2:0], res_taken};
            end
        end
    end

`ifdef BHR_SPEC_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resolve_count    <= '0;
            mispredict_count <= '0;
        end else begin
            if (res_fire && (resolve_count != '1)) begin
                resolve_count <= resolve_count + BHR_CNT_W'(1);
            end
            if (mis_event && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + BHR_CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_bhr_spec_ctrl.sv
// Self-checking bench for bhr_spec_ctrl: directed scenarios plus random traffic against a queue model.
module tb_bhr_spec_ctrl;

    localparam int M     = 4;
    localparam int DEPTH = 4;
    localparam int OCC_W = $clog2(DEPTH+1);

    logic             clk;
    logic             reset;
    logic             pred_valid;
    logic             pred_taken;
    logic             pred_ready;
    logic             res_valid;
    logic             res_taken;
    logic             res_ready;
    logic [M-1:0]     spec_hist;
    logic [M-1:0]     arch_hist;
    logic             mispredict;
    logic [OCC_W-1:0] occupancy;
`ifdef BHR_SPEC_STATS_EN
    logic [15:0]      resolve_count;
    logic [15:0]      mispredict_count;
`endif

    bhr_spec_ctrl #(
        .M     (M),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_ready (pred_ready),
        .res_valid  (res_valid),
        .res_taken  (res_taken),
        .res_ready  (res_ready),
        .spec_hist  (spec_hist),
        .arch_hist  (arch_hist),
        .mispredict (mispredict),
        .occupancy  (occupancy)
`ifdef BHR_SPEC_STATS_EN
        ,
        .resolve_count    (resolve_count),
        .mispredict_count (mispredict_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queue of outstanding predictions plus plain history values.
    bit [M-1:0] m_spec;
    bit [M-1:0] m_arch;
    bit         m_q[$];
    bit         m_recover;
    bit         m_mis;
    int         m_res_cnt;
    int         m_mis_cnt;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_spec    = '0;
        m_arch    = '0;
        m_q.delete();
        m_recover = 1'b0;
        m_mis     = 1'b0;
        m_res_cnt = 0;
        m_mis_cnt = 0;
    endtask

    task automatic compareModel();
        checkOutput("spec_hist",  32'(spec_hist),  32'(m_spec));
        checkOutput("arch_hist",  32'(arch_hist),  32'(m_arch));
        checkOutput("occupancy",  32'(occupancy),  32'(m_q.size()));
        checkOutput("pred_ready", 32'(pred_ready), 32'(!m_recover && (m_q.size() < DEPTH)));
        checkOutput("res_ready",  32'(res_ready),  32'(m_q.size() != 0));
        checkOutput("mispredict", 32'(mispredict), 32'(m_mis));
`ifdef BHR_SPEC_STATS_EN
        checkOutput("resolve_count",    32'(resolve_count),    32'(m_res_cnt));
        checkOutput("mispredict_count", 32'(mispredict_count), 32'(m_mis_cnt));
`endif
    endtask

    // Called at a falling edge: drive inputs, advance the model, cross one rising edge, compare.
    task automatic applyStimulus(input bit pv, input bit pt, input bit rv, input bit rt);
        bit pr;
        bit rr;
        bit oldest;
        bit mis;
        pred_valid = pv;
        pred_taken = pt;
        res_valid  = rv;
        res_taken  = rt;
        pr  = !m_recover && (m_q.size() < DEPTH);
        rr  = (m_q.size() != 0);
        mis = 1'b0;
        if (rv && rr) begin
            oldest = m_q.pop_front();
            mis    = (oldest != rt);
            if (m_res_cnt < 65535) m_res_cnt++;
        end
        if (mis) begin
            m_spec = {m_arch[M-2:0], rt};
            m_q.delete();
            if (m_mis_cnt < 65535) m_mis_cnt++;
        end else if (pv && pr) begin
            m_spec = {m_spec[M-2:0], pt};
            m_q.push_back(pt);
        end
        if (rv && rr) m_arch = {m_arch[M-2:0], rt};
        m_recover = mis;
        m_mis     = mis;
        @(posedge clk);
        @(negedge clk);
        compareModel();
    endtask

    initial begin
        bit pv;
        bit pt;
        bit rv;
        bit rt;
        bit [3:0] pat;

        reset      = 1'b1;
        pred_valid = 1'b0;
        pred_taken = 1'b0;
        res_valid  = 1'b0;
        res_taken  = 1'b0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        compareModel();
        checkOutput("rst_pred_ready", 32'(pred_ready), 32'd1);
        checkOutput("rst_res_ready",  32'(res_ready),  32'd0);

        // Fill the queue with taken,taken,not-taken,taken.
        pat = 4'b1101;
        for (int i = 3; i >= 0; i--) applyStimulus(1'b1, pat[i], 1'b0, 1'b0);
        checkOutput("fill_spec",  32'(spec_hist),  32'hD);
        checkOutput("fill_occ",   32'(occupancy),  32'd4);
        checkOutput("fill_ready", 32'(pred_ready), 32'd0);
        checkOutput("fill_arch",  32'(arch_hist),  32'd0);

        // Drain with matching outcomes.
        for (int i = 3; i >= 0; i--) applyStimulus(1'b0, 1'b0, 1'b1, pat[i]);
        checkOutput("drain_arch",  32'(arch_hist), 32'hD);
        checkOutput("drain_occ",   32'(occupancy), 32'd0);
        checkOutput("drain_ready", 32'(res_ready), 32'd0);

        // Build arch_hist = 0011, then queue 1,1,1 and mispredict the oldest.
        pat = 4'b0011;
        for (int i = 3; i >= 0; i--) applyStimulus(1'b1, pat[i], 1'b0, 1'b0);
        for (int i = 3; i >= 0; i--) applyStimulus(1'b0, 1'b0, 1'b1, pat[i]);
        checkOutput("pre_arch", 32'(arch_hist), 32'h3);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("mis_pulse", 32'(mispredict), 32'd1);
        checkOutput("mis_spec",  32'(spec_hist),  32'h6);
        checkOutput("mis_arch",  32'(arch_hist),  32'h6);
        checkOutput("mis_occ",   32'(occupancy),  32'd0);
        checkOutput("mis_ready", 32'(pred_ready), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("recover_done", 32'(pred_ready), 32'd1);
        checkOutput("recover_drop", 32'(occupancy),  32'd0);

        // Simultaneous push and matching resolve at occupancy 2.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("both_occ",  32'(occupancy), 32'd2);
        checkOutput("both_spec", 32'(spec_hist), 32'h5);
        checkOutput("both_arch", 32'(arch_hist), 32'hD);

        // Simultaneous push and mispredicting resolve: push is squashed.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("squash_occ",  32'(occupancy), 32'd0);
        checkOutput("squash_spec", 32'(spec_hist), 32'hB);
        checkOutput("squash_mis",  32'(mispredict), 32'd1);

        // Asynchronous reset with three checkpoints queued.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'(i), 1'b0, 1'b0);
        checkOutput("pre_rst_occ", 32'(occupancy), 32'd3);
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_spec", 32'(spec_hist),  32'd0);
        checkOutput("arst_arch", 32'(arch_hist),  32'd0);
        checkOutput("arst_occ",  32'(occupancy),  32'd0);
        checkOutput("arst_mis",  32'(mispredict), 32'd0);
        checkOutput("arst_rrdy", 32'(res_ready),  32'd0);
`ifdef BHR_SPEC_STATS_EN
        checkOutput("arst_rcnt", 32'(resolve_count),    32'd0);
        checkOutput("arst_mcnt", 32'(mispredict_count), 32'd0);
`endif
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        compareModel();

        // Random traffic; resolutions mostly agree with the oldest prediction.
        for (int c = 0; c < 400; c++) begin
            pv = 1'($urandom_range(0, 3) != 0);
            pt = 1'($urandom);
            rv = 1'($urandom_range(0, 2) == 0);
            if (m_q.size() != 0) rt = ($urandom_range(0, 5) == 0) ? !m_q[0] : m_q[0];
            else rt = 1'($urandom);
            applyStimulus(pv, pt, rv, rt);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
